// File: rtl/iob_eth_frame_gen.sv
// Ethernet frame generator for MII (4-bit) or GMII (8-bit) receive-side stimulus.
// Emits preamble, SFD, header, patterned payload, zero pad and CRC-32 FCS for a burst of frames.
module iob_eth_frame_gen #(
  parameter int DATA_W       = 4,
  parameter int PREAMBLE_LEN = 7,
  parameter int LEN_W        = 11,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int MIN_PAYLOAD  = 46,
  parameter int IFG_BYTES    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [15:0]       n_frames,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic              pattern,
  input  logic              crc_err,
  input  logic [47:0]       dst_mac,
  input  logic [47:0]       src_mac,
  input  logic [15:0]       eth_type,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_dv,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_HDR  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_PAD  = 3'd5;
  localparam logic [2:0] S_FCS  = 3'd6;
  localparam logic [2:0] S_IFG  = 3'd7;

  localparam logic [15:0] PRE_LEN   = 16'(PREAMBLE_LEN);
  localparam logic [15:0] MIN_LEN   = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD);
  localparam logic [15:0] IFG_LEN   = 16'(IFG_BYTES);
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [7:0]  LFSR_SEED = 8'hFF;
  localparam logic        NIB_MODE  = (DATA_W == 4);

  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ({1'b0, r[31:1]} ^ 32'hEDB8_8320) : {1'b0, r[31:1]};
    end
    return r;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [15:0] seg_len(input logic [2:0] st, input logic [15:0] len);
    logic [15:0] n;
    case (st)
      S_PRE:   n = PRE_LEN;
      S_SFD:   n = 16'd1;
      S_HDR:   n = 16'd14;
      S_PAY:   n = len;
      S_PAD:   n = MIN_LEN - len;
      S_FCS:   n = 16'd4;
      S_IFG:   n = IFG_LEN;
      default: n = 16'd1;
    endcase
    return n;
  endfunction

  // The FCS byte is taken from the complemented CRC, least significant byte first.
  function automatic logic [7:0] frame_byte(input logic [2:0] st, input logic [7:0] idx,
                                            input logic [7:0] lfsr, input logic [31:0] crc,
                                            input logic [111:0] hdr, input logic pat,
                                            input logic err);
    logic [7:0]   b;
    logic [111:0] hsh;
    logic [31:0]  fsh;
    hsh = hdr << {idx[3:0], 3'b000};
    fsh = (~crc) >> {idx[1:0], 3'b000};
    case (st)
      S_PRE:   b = 8'h55;
      S_SFD:   b = 8'hD5;
      S_HDR:   b = hsh[111:104];
      S_PAY:   b = pat ? lfsr : idx;
      S_PAD:   b = 8'h00;
      S_FCS:   b = {fsh[7:1], fsh[0] ^ (err && (idx[1:0] == 2'd0))};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [2:0]        state_r;
  logic [15:0]       cnt_r;
  logic              nib_r;
  logic [31:0]       crc_r;
  logic [7:0]        lfsr_r;
  logic [111:0]      hdr_r;
  logic [15:0]       len_r;
  logic              pat_r;
  logic              err_r;
  logic [15:0]       left_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              tx_dv_r;
  logic              busy_r;
  logic              done_r;
  logic [15:0]       frame_cnt_r;

  logic              last_beat_s;
  logic              byte_end_s;
  logic              frame_end_s;
  logic [7:0]        cur_byte_s;
  logic [7:0]        nxt_byte_s;
  logic [2:0]        nxt_state_s;
  logic [15:0]       nxt_cnt_s;
  logic              nxt_nib_s;
  logic [31:0]       nxt_crc_s;
  logic [7:0]        nxt_lfsr_s;
  logic              nxt_dv_s;
  logic [DATA_W-1:0] nxt_data_s;
  logic [15:0]       pay_len_s;

  // The registered state names the beat currently on tx_data; this computes the following beat.
  always_comb begin
    pay_len_s   = (16'(payload_len) > MAX_LEN) ? MAX_LEN : 16'(payload_len);
    last_beat_s = NIB_MODE ? nib_r : 1'b1;
    byte_end_s  = last_beat_s && (cnt_r == (seg_len(state_r, len_r) - 16'd1));
    frame_end_s = byte_end_s && (state_r == S_FCS);
    cur_byte_s  = frame_byte(state_r, cnt_r[7:0], lfsr_r, crc_r, hdr_r, pat_r, err_r);
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_nib_s   = 1'b0;
    if (!last_beat_s) begin
      nxt_nib_s = 1'b1;
    end else if (byte_end_s) begin
      nxt_cnt_s = 16'd0;
      case (state_r)
        S_PRE:   nxt_state_s = S_SFD;
        S_SFD:   nxt_state_s = S_HDR;
        S_HDR:   nxt_state_s = (len_r == 16'd0) ? S_PAD : S_PAY;
        S_PAY:   nxt_state_s = (len_r < MIN_LEN) ? S_PAD : S_FCS;
        S_PAD:   nxt_state_s = S_FCS;
        S_FCS:   nxt_state_s = S_IFG;
        S_IFG:   nxt_state_s = (left_r != 16'd0) ? S_PRE : S_IDLE;
        default: nxt_state_s = S_IDLE;
      endcase
    end else begin
      nxt_cnt_s = cnt_r + 16'd1;
    end

    // CRC covers header, payload and pad; it freezes while the FCS is being sent.
    if (last_beat_s && ((state_r == S_HDR) || (state_r == S_PAY) || (state_r == S_PAD))) begin
      nxt_crc_s = crc_step(crc_r, cur_byte_s);
    end else if (nxt_state_s == S_PRE) begin
      nxt_crc_s = CRC_INIT;
    end else begin
      nxt_crc_s = crc_r;
    end
    if (last_beat_s && (state_r == S_PAY)) begin
      nxt_lfsr_s = lfsr_step(lfsr_r);
    end else if (nxt_state_s == S_PRE) begin
      nxt_lfsr_s = LFSR_SEED;
    end else begin
      nxt_lfsr_s = lfsr_r;
    end

    nxt_byte_s = frame_byte(nxt_state_s, nxt_cnt_s[7:0], nxt_lfsr_s, nxt_crc_s, hdr_r, pat_r, err_r);
    nxt_dv_s   = (nxt_state_s != S_IDLE) && (nxt_state_s != S_IFG);
    nxt_data_s = nxt_dv_s ? DATA_W'(nxt_byte_s >> {nxt_nib_s, 2'b00}) : {DATA_W{1'b0}};
  end

  // Burst sequencer and registered outputs; everything except the done pulse holds when en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= 16'd0;
      nib_r       <= 1'b0;
      crc_r       <= CRC_INIT;
      lfsr_r      <= LFSR_SEED;
      hdr_r       <= 112'd0;
      len_r       <= 16'd0;
      pat_r       <= 1'b0;
      err_r       <= 1'b0;
      left_r      <= 16'd0;
      tx_data_r   <= {DATA_W{1'b0}};
      tx_dv_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      done_r <= 1'b0;
      if (en && (state_r == S_IDLE)) begin
        if (start) begin
          hdr_r       <= {dst_mac, src_mac, eth_type};
          len_r       <= pay_len_s;
          pat_r       <= pattern;
          err_r       <= crc_err;
          left_r      <= n_frames;
          crc_r       <= CRC_INIT;
          lfsr_r      <= LFSR_SEED;
          busy_r      <= 1'b1;
          frame_cnt_r <= 16'd0;
          // An empty burst parks on the last gap beat so it ends on the next enabled cycle.
          if (n_frames == 16'd0) begin
            state_r   <= S_IFG;
            cnt_r     <= IFG_LEN - 16'd1;
            nib_r     <= NIB_MODE;
            tx_dv_r   <= 1'b0;
            tx_data_r <= {DATA_W{1'b0}};
          end else begin
            state_r   <= S_PRE;
            cnt_r     <= 16'd0;
            nib_r     <= 1'b0;
            tx_dv_r   <= 1'b1;
            tx_data_r <= DATA_W'(8'h55);
          end
        end else begin
          busy_r <= 1'b0;
        end
      end else if (en) begin
        state_r   <= nxt_state_s;
        cnt_r     <= nxt_cnt_s;
        nib_r     <= nxt_nib_s;
        crc_r     <= nxt_crc_s;
        lfsr_r    <= nxt_lfsr_s;
        tx_dv_r   <= nxt_dv_s;
        tx_data_r <= nxt_data_s;
        busy_r    <= (nxt_state_s != S_IDLE);
        done_r    <= (nxt_state_s == S_IDLE);
        if (frame_end_s) begin
          frame_cnt_r <= frame_cnt_r + 16'd1;
          left_r      <= left_r - 16'd1;
        end else begin
          frame_cnt_r <= frame_cnt_r;
        end
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign tx_data   = tx_data_r;
  assign tx_dv     = tx_dv_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_iob_eth_frame_gen.sv
// Directed/random bench for iob_eth_frame_gen: MII and GMII instances, a byte-level frame model
// built from queues, and an independent CRC residue check on the captured beats.
module tb_iob_eth_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, start4, start8, pattern, crc_err, dw8;
  logic [15:0] n_frames, eth_type;
  logic [10:0] payload_len;
  logic [47:0] dst_mac, src_mac;
  logic [3:0]  tx_data4;
  logic [7:0]  tx_data8;
  logic        tx_dv4, busy4, done4, tx_dv8, busy8, done8;
  logic [15:0] frame_cnt4, frame_cnt8;

  iob_eth_frame_gen #(.DATA_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start4), .n_frames(n_frames),
    .payload_len(payload_len), .pattern(pattern), .crc_err(crc_err), .dst_mac(dst_mac),
    .src_mac(src_mac), .eth_type(eth_type), .tx_data(tx_data4), .tx_dv(tx_dv4),
    .busy(busy4), .done(done4), .frame_cnt(frame_cnt4)
  );

  iob_eth_frame_gen #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start8), .n_frames(n_frames),
    .payload_len(payload_len), .pattern(pattern), .crc_err(crc_err), .dst_mac(dst_mac),
    .src_mac(src_mac), .eth_type(eth_type), .tx_data(tx_data8), .tx_dv(tx_dv8),
    .busy(busy8), .done(done8), .frame_cnt(frame_cnt8)
  );

  logic        m_dv, m_busy, m_done;
  logic [7:0]  m_data;
  logic [15:0] m_cnt;
  always_comb begin
    m_dv   = dw8 ? tx_dv8 : tx_dv4;
    m_busy = dw8 ? busy8 : busy4;
    m_done = dw8 ? done8 : done4;
    m_data = dw8 ? tx_data8 : {4'h0, tx_data4};
    m_cnt  = dw8 ? frame_cnt8 : frame_cnt4;
  end

  int tests = 0;
  int fails = 0;

  bit          rec_dv[$];
  logic [7:0]  rec_data[$];
  logic [15:0] rec_fc[$];
  bit          exp_dv[$];
  logic [7:0]  exp_data[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int k = 0; k < 8; k++) begin
      fb = c[0] ^ b[k];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] b, input int dw);
    if (dw == 4) begin
      exp_dv.push_back(1'b1); exp_data.push_back({4'h0, b[3:0]});
      exp_dv.push_back(1'b1); exp_data.push_back({4'h0, b[7:4]});
    end else begin
      exp_dv.push_back(1'b1); exp_data.push_back(b);
    end
  endtask

  // Reference: every frame as a list of bytes, expanded to beats plus the idle gap.
  task automatic build_model(input int n, input int plen, input bit pat, input bit err,
                             input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                             input int dw);
    logic [7:0]  fr[$];
    logic [7:0]  l, fb;
    logic [31:0] c;
    int          len, eff;
    exp_dv.delete(); exp_data.delete();
    len = (plen > 1500) ? 1500 : plen;
    eff = (len < 46) ? 46 : len;
    for (int f = 0; f < n; f++) begin
      fr.delete();
      for (int i = 0; i < 6; i++) fr.push_back(d[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fr.push_back(s[47-8*i -: 8]);
      fr.push_back(t[15:8]); fr.push_back(t[7:0]);
      l = 8'hFF;
      for (int i = 0; i < eff; i++) begin
        if (i < len) begin
          fr.push_back(pat ? l : 8'(i));
          l = {l[6:0], ^(l & 8'hB8)};
        end else fr.push_back(8'h00);
      end
      c = 32'hFFFFFFFF;
      foreach (fr[i]) c = crc_upd(c, fr[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) begin
        fb = c[8*k +: 8];
        if (err && k == 0) fb = fb ^ 8'h01;
        fr.push_back(fb);
      end
      for (int i = 0; i < 7; i++) push_byte(8'h55, dw);
      push_byte(8'hD5, dw);
      foreach (fr[i]) push_byte(fr[i], dw);
      for (int i = 0; i < 12 * 8 / dw; i++) begin
        exp_dv.push_back(1'b0); exp_data.push_back(8'h00);
      end
    end
  endtask

  // Starts the selected instance and records one beat per enabled cycle until done.
  task automatic run_burst(input bit rnd);
    bit got;
    int busy_bad;
    got = 1'b0; busy_bad = 0;
    rec_dv.delete(); rec_data.delete(); rec_fc.delete();
    @(negedge clk);
    en = 1'b1;
    if (dw8) start8 = 1'b1; else start4 = 1'b1;
    for (int cyc = 0; cyc < 20000 && !got; cyc++) begin
      @(negedge clk);
      if (m_done) begin
        got = 1'b1; start4 = 1'b0; start8 = 1'b0;
      end else begin
        if (m_busy !== 1'b1) busy_bad++;
        en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (dw8) start8 = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
        else     start4 = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
        if (rnd) begin
          payload_len = 11'($urandom_range(0, 1600));
          crc_err     = 1'($urandom_range(0, 1));
          dst_mac     = {$urandom, $urandom};
          eth_type    = 16'($urandom);
        end
        if (en) begin
          rec_dv.push_back(m_dv); rec_data.push_back(m_data); rec_fc.push_back(m_cnt);
        end
      end
    end
    en = 1'b1;
    check("burst_done_seen", got, 1);
    check("busy_during_burst", busy_bad, 0);
    @(negedge clk);
    check("done_single_pulse", m_done, 0);
    check("busy_after_done", m_busy, 0);
  endtask

  task automatic compare(input string tag);
    int nbad, first;
    nbad = 0; first = -1;
    check({tag, "_beat_count"}, rec_dv.size(), exp_dv.size());
    for (int i = 0; i < rec_dv.size() && i < exp_dv.size(); i++) begin
      if (rec_dv[i] !== exp_dv[i] || (exp_dv[i] && rec_data[i] !== exp_data[i])) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0)
      $display("  %s first differing beat %0d: dv=%0b data=%0h, model dv=%0b data=%0h",
               tag, first, rec_dv[first], rec_data[first], exp_dv[first], exp_data[first]);
    check({tag, "_beats_differing"}, nbad, 0);
  endtask

  // Independent of the model: CRC residue over dst..FCS and frame_cnt at every frame end.
  task automatic check_frames(input string tag, input int n, input bit err, input int dw);
    logic [7:0]  by[$];
    logic [7:0]  cur;
    logic [31:0] c;
    bit          hi;
    int          nfr;
    nfr = 0; hi = 1'b0; cur = 8'h00;
    for (int i = 0; i < rec_dv.size(); i++) begin
      if (rec_dv[i]) begin
        if (dw == 8) by.push_back(rec_data[i]);
        else if (!hi) begin cur[3:0] = rec_data[i][3:0]; hi = 1'b1; end
        else begin cur[7:4] = rec_data[i][3:0]; by.push_back(cur); hi = 1'b0; end
      end else if (i > 0 && rec_dv[i-1]) begin
        nfr++;
        check({tag, "_frame_cnt"}, rec_fc[i], nfr);
        c = 32'hFFFFFFFF;
        for (int k = 8; k < by.size(); k++) c = crc_upd(c, by[k]);
        if (err) check({tag, "_residue_corrupt"}, (c != 32'hDEBB20E3), 1);
        else     check({tag, "_residue"}, c, 32'hDEBB20E3);
        by.delete(); hi = 1'b0;
      end
    end
    check({tag, "_frames"}, nfr, n);
  endtask

  task automatic do_burst(input string tag, input int dw, input int n, input int plen,
                          input bit pat, input bit err, input bit rnd);
    dw8 = (dw == 8); n_frames = 16'(n); payload_len = 11'(plen); pattern = pat; crc_err = err;
    build_model(n, plen, pat, err, dst_mac, src_mac, eth_type, dw);
    run_burst(rnd);
    compare(tag);
    check_frames(tag, n, err, dw);
  endtask

  int ndv;

  initial begin
    rst_n = 1'b0; en = 1'b0; start4 = 1'b0; start8 = 1'b0; dw8 = 1'b0;
    n_frames = 16'd1; payload_len = 11'd46; pattern = 1'b0; crc_err = 1'b0;
    dst_mac = 48'h01606E11020F; src_mac = 48'h01606E11020F; eth_type = 16'h0800;
    repeat (3) @(negedge clk);
    check("rst_tx_dv", tx_dv4, 0);
    check("rst_tx_data", tx_data4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_frame_cnt", frame_cnt4, 0);
    check("rst_tx_dv8", tx_dv8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Step 1: MII, single minimum frame with fixed addresses.
    do_burst("t1", 4, 1, 46, 1'b0, 1'b0, 1'b0);
    ndv = 0;
    foreach (rec_dv[i]) ndv += int'(rec_dv[i]);
    check("t1_dv_beats", ndv, 144);
    check("t1_idle_beats", rec_dv.size() - ndv, 24);
    check("t1_pre_last", rec_data[13], 8'h05);
    check("t1_sfd_lo", rec_data[14], 8'h05);
    check("t1_sfd_hi", rec_data[15], 8'h0D);
    check("t1_dst_b0", rec_data[16], 8'h01);
    check("t1_dst_b1", rec_data[17], 8'h00);
    check("t1_pay_nibbles", {rec_data[44][3:0], rec_data[45][3:0], rec_data[46][3:0],
                             rec_data[47][3:0], rec_data[48][3:0], rec_data[49][3:0]}, 24'h001020);
    check("t1_frame_cnt", m_cnt, 1);

    // Step 2: short payload gets padded, oversize payload gets clamped.
    dst_mac = {$urandom, $urandom}; src_mac = {$urandom, $urandom}; eth_type = 16'($urandom);
    do_burst("t2_short", 4, 1, 10, 1'b0, 1'b0, 1'b0);
    check("t2_last_pay_byte", {rec_data[63][3:0], rec_data[62][3:0]}, 8'h09);
    do_burst("t2_clamp", 8, 1, 2000, 1'b0, 1'b0, 1'b0);
    ndv = 0;
    foreach (rec_dv[i]) ndv += int'(rec_dv[i]);
    check("t2_clamp_dv_beats", ndv, 8 + 14 + 1500 + 4);

    // Step 3: three corrupted frames back to back.
    do_burst("t3", 4, 3, $urandom_range(0, 100), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("t3_frame_cnt", m_cnt, 3);

    // Step 4: GMII with LFSR payload.
    do_burst("t4", 8, 2, 46, 1'b1, 1'b0, 1'b0);
    ndv = 0;
    foreach (rec_dv[i]) ndv += int'(rec_dv[i]);
    check("t4_dv_beats", ndv, 144);
    check("t4_first_lfsr", rec_data[22], 8'hFF);

    // Step 5: random enable, config churn and stray starts while busy.
    dst_mac = {$urandom, $urandom};
    do_burst("t5_mii", 4, 2, $urandom_range(0, 120), 1'b1, 1'b0, 1'b1);
    dst_mac = {$urandom, $urandom};
    do_burst("t5_gmii", 8, 2, $urandom_range(40, 300), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    do_burst("t5_zero_len", 8, 1, 0, 1'b0, 1'b0, 1'b1);
    dw8 = 1'b0; n_frames = 16'd0;
    run_burst(1'b0);
    check("t5_nf0_busy_beats", rec_dv.size(), 1);
    check("t5_nf0_no_dv", rec_dv.size() > 0 ? rec_dv[0] : 1'b1, 0);
    check("t5_nf0_frame_cnt", m_cnt, 0);

    // Step 6: asynchronous reset in the middle of the payload, then a clean frame.
    dw8 = 1'b1; n_frames = 16'd1; payload_len = 11'd100; pattern = 1'b0; crc_err = 1'b0;
    @(negedge clk);
    en = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (29) @(negedge clk);
    check("t6_active_before_rst", tx_dv8, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_tx_dv", tx_dv8, 0);
    check("t6_rst_busy", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_burst("t6_after", 8, 1, 60, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
